// File: rtl/demux4_buf_pkg.sv
// demux4_buf_pkg: shared definitions for the demux4_buf slice.
//   WORD        default data width of the demultiplexed word
//   NUM_DEST    number of downstream consumers
//   buf_state_e occupancy state of the 2-entry buffer (encoding == count)
//   sel_onehot  2-bit destination select -> 4-bit one-hot lane mask
package demux4_buf_pkg;

    localparam int unsigned WORD     = 64;
    localparam int unsigned NUM_DEST = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    function automatic logic [NUM_DEST-1:0] sel_onehot(input logic [1:0] sel);
        logic [NUM_DEST-1:0] mask;
        mask = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux4_buf_buf2.sv
// demux4_buf_buf2: generic 2-entry valid/ready buffer (head + skid), strict FIFO.
//   clk, rst      clock, synchronous active-high reset
//   i_valid       producer has a word
//   o_ready       buffer can accept a word (registered-state based, gated by rst)
//   i_data        word to store
//   o_head_valid  head entry holds a word
//   o_head_data   head entry contents
//   i_pop         consumer takes the head this cycle
//   o_count       occupancy 0..2
module demux4_buf_buf2
    import demux4_buf_pkg::*;
#(
    parameter int unsigned W = WORD + 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_head_valid,
    output logic [W-1:0] o_head_data,
    input  logic         i_pop,
    output logic [1:0]   o_count
);

    buf_state_e   r_state;
    logic [W-1:0] r_head_data;
    logic [W-1:0] r_skid_data;
    logic         r_head_valid;
    logic         r_skid_valid;

    logic         w_push;
    logic         w_pop;

    assign o_ready = !rst && (r_state != TWO);
    assign w_push  = i_valid && o_ready;
    assign w_pop   = i_pop && r_head_valid;

    // Data registers carry no reset value: every consumer-visible use is
    // qualified by the corresponding valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_head_data  <= i_data;
                        r_head_valid <= 1'b1;
                        r_state      <= ONE;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        // departing head is replaced in place; occupancy stays 1
                        r_head_data <= i_data;
                    end else if (w_push) begin
                        r_skid_data  <= i_data;
                        r_skid_valid <= 1'b1;
                        r_state      <= TWO;
                    end else if (w_pop) begin
                        r_head_valid <= 1'b0;
                        r_state      <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_head_data  <= r_skid_data;
                        r_head_valid <= r_skid_valid;
                        r_skid_valid <= 1'b0;
                        r_state      <= ONE;
                    end
                end
                default: begin
                    r_state      <= EMPTY;
                    r_head_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_head_valid = r_head_valid;
    assign o_head_data  = r_head_data;
    assign o_count      = r_state;

endmodule

// File: rtl/demux4_buf.sv
// demux4_buf: registered 1-to-4 demultiplexer with valid/ready handshakes.
// A 2-entry FIFO holds {sel, data}; the head word is offered only to the
// destination named by its sel, so later words wait behind a stalled head.
//   clk, rst   clock, synchronous active-high reset
//   in_valid   producer has a word
//   in_ready   block can accept a word this cycle
//   in_data    word to route (SIZE bits)
//   in_sel     destination 0..3 (a..d)
//   out_valid  one-hot offer to destination i
//   out_ready  consumer i accepts (ignored when not offered)
//   a, b, c, d per-destination data, zero unless offered
//   count      buffer occupancy 0..2
module demux4_buf
    import demux4_buf_pkg::*;
#(
    parameter int unsigned SIZE = WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_data,
    input  logic [1:0]      in_sel,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [SIZE-1:0] a,
    output logic [SIZE-1:0] b,
    output logic [SIZE-1:0] c,
    output logic [SIZE-1:0] d,
    output logic [1:0]      count
);

    logic            w_head_valid;
    logic [SIZE+1:0] w_head;
    logic [1:0]      w_head_sel;
    logic [SIZE-1:0] w_head_data;
    logic [3:0]      w_out_valid;
    logic            w_pop;

    demux4_buf_buf2 #(
        .W (SIZE + 2)
    ) u_buf2 (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (in_valid),
        .o_ready      (in_ready),
        .i_data       ({in_sel, in_data}),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head),
        .i_pop        (w_pop),
        .o_count      (count)
    );

    assign {w_head_sel, w_head_data} = w_head;

    always_comb begin
        w_out_valid = '0;
        if (w_head_valid) begin
            w_out_valid = sel_onehot(w_head_sel);
        end
    end

    // Only the offered lane's ready can retire the head.
    assign w_pop     = |(w_out_valid & out_ready);
    assign out_valid = w_out_valid;

    assign a = w_out_valid[0] ? w_head_data : '0;
    assign b = w_out_valid[1] ? w_head_data : '0;
    assign c = w_out_valid[2] ? w_head_data : '0;
    assign d = w_out_valid[3] ? w_head_data : '0;

endmodule

// File: tb/tb_demux4_buf.sv
module tb_demux4_buf;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [W-1:0] a, b, c, d;
    logic [1:0]   count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux4_buf #(.SIZE(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .count     (count)
    );

    // Reference: a plain FIFO of at most two {sel, data} items.
    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } item_t;

    item_t q[$];

    typedef logic [1+2+4+4*W-1:0] obs_t;

    function automatic obs_t model_obs();
        logic         rdy;
        logic [1:0]   cnt;
        logic [3:0]   ov;
        logic [W-1:0] dv[4];
        rdy = !rst && (q.size() < 2);
        cnt = 2'(q.size());
        ov  = '0;
        for (int i = 0; i < 4; i++) dv[i] = '0;
        if (q.size() > 0) begin
            ov[q[0].sel] = 1'b1;
            dv[q[0].sel] = q[0].data;
        end
        return {rdy, cnt, ov, dv[0], dv[1], dv[2], dv[3]};
    endfunction

    function automatic obs_t dut_obs();
        return {in_ready, count, out_valid, a, b, c, d};
    endfunction

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic tick();
        bit push, pop;
        item_t it;
        push = in_valid && !rst && (q.size() < 2);
        pop  = !rst && (q.size() > 0) && out_ready[q[0].sel];
        it   = '{sel: in_sel, data: in_data};
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(it);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready);
        end
        checks++;
        if ({out_valid, count} !== 6'b0) begin
            errors++; $display("FAIL reset_state got ov=%b cnt=%0d exp ov=0000 cnt=0", out_valid, count);
        end
        checks++;
        if ((a | b | c | d) !== '0) begin
            errors++; $display("FAIL reset_data got a=%h b=%h c=%h d=%h exp all 0", a, b, c, d);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 64'h1234; in_sel = 2'b10; out_ready = 4'b1111;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0100 || c !== 64'h1234) begin
            errors++; $display("FAIL single_offer got ov=%b c=%h exp ov=0100 c=1234", out_valid, c);
        end
        checks++;
        if ((a | b | d) !== '0) begin
            errors++; $display("FAIL single_gating got a=%h b=%h d=%h exp 0", a, b, d);
        end
        tick();
        checks++;
        if (count !== 2'd0) begin
            errors++; $display("FAIL single_drain got count=%0d exp 0", count);
        end
    endtask

    task automatic test_streaming();
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 64'h10 + 64'(i); in_sel = 2'(i);
            tick();
            checks++;
            if (out_valid !== (4'b0001 << i) || in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_%0d got ov=%b rdy=%b exp ov=%b rdy=1", i, out_valid, in_ready, 4'b0001 << i);
            end
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++; $display("FAIL stream_obs_%0d got %h exp %h", i, dut_obs(), model_obs());
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (count !== 2'd0) begin
            errors++; $display("FAIL stream_drain got count=%0d exp 0", count);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 64'hA0; in_sel = 2'b01;
        tick();
        in_data = 64'hA1; in_sel = 2'b11;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 2'd2 || in_ready !== 1'b0 || out_valid !== 4'b0010 || b !== 64'hA0) begin
            errors++; $display("FAIL bp_full got cnt=%0d rdy=%b ov=%b b=%h exp cnt=2 rdy=0 ov=0010 b=a0", count, in_ready, out_valid, b);
        end
        tick();
        checks++;
        if (out_valid !== 4'b0010 || b !== 64'hA0) begin
            errors++; $display("FAIL bp_stable got ov=%b b=%h exp ov=0010 b=a0", out_valid, b);
        end
        out_ready = 4'b0010;
        tick();
        out_ready = 4'b0000;
        #1;
        checks++;
        if (out_valid !== 4'b1000 || d !== 64'hA1 || count !== 2'd1) begin
            errors++; $display("FAIL bp_release got ov=%b d=%h cnt=%0d exp ov=1000 d=a1 cnt=1", out_valid, d, count);
        end
        out_ready = 4'b1111;
        tick();
        checks++;
        if (dut_obs() !== model_obs()) begin
            errors++; $display("FAIL bp_drain got %h exp %h", dut_obs(), model_obs());
        end
    endtask

    task automatic test_hol();
        out_ready = 4'b1110;
        in_valid = 1'b1; in_data = 64'hB0; in_sel = 2'b00;
        tick();
        in_data = 64'hB1; in_sel = 2'b01;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 4'b0001 || a !== 64'hB0 || b !== '0) begin
                errors++; $display("FAIL hol_block_%0d got ov=%b a=%h b=%h exp ov=0001 a=b0 b=0", i, out_valid, a, b);
            end
        end
        out_ready = 4'b0001;
        tick();
        checks++;
        if (out_valid !== 4'b0010 || b !== 64'hB1) begin
            errors++; $display("FAIL hol_release got ov=%b b=%h exp ov=0010 b=b1", out_valid, b);
        end
        out_ready = 4'b1111;
        tick();
        checks++;
        if (count !== 2'd0) begin
            errors++; $display("FAIL hol_drain got count=%0d exp 0", count);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 64'hC0; in_sel = 2'b10;
        tick();
        in_data = 64'hC1; in_sel = 2'b11;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 2'd2) begin
            errors++; $display("FAIL rmid_fill got count=%0d exp 2", count);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (count !== 2'd0 || out_valid !== 4'b0000 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rmid_reset got cnt=%0d ov=%b rdy=%b exp cnt=0 ov=0000 rdy=0", count, out_valid, in_ready);
        end
        rst = 1'b0;
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 4'b0000 || (a | b | c | d) !== '0) begin
                errors++; $display("FAIL rmid_ghost_%0d got ov=%b c=%h d=%h exp ov=0000 all 0", i, out_valid, c, d);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 79) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = {$urandom, $urandom};
            out_ready = 4'($urandom);
            if (n % 100 < 30) out_ready = 4'b1111;
            tick();
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++; $display("FAIL random_%0d got %h exp %h", n, dut_obs(), model_obs());
            end
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 4'b1111;
        tick();
        tick();
        checks++;
        if (dut_obs() !== model_obs()) begin
            errors++; $display("FAIL random_drain got %h exp %h", dut_obs(), model_obs());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_hol();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
